// File: rtl/ksa_shuffler_pkg.sv
// Shared constants and state encoding for the RC4 S-array stages (populator, shuffler, top mux).
package ksa_shuffler_pkg;

    localparam int S_ADDR_W = 8;
    localparam int S_DATA_W = 8;
    localparam int S_DEPTH  = 2 ** S_ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        READ_SI,
        WAIT_SI,
        READ_SJ,
        WAIT_SJ,
        WRITE_SI,
        WRITE_SJ,
        DONE
    } state_t;

endpackage

// File: rtl/ksa_shuffler_if.sv
// S-array RAM bus plus start/key/finish handshake between the shuffler (master) and its environment.
interface ksa_shuffler_if
    import ksa_shuffler_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int ADDR_W    = S_ADDR_W,
    parameter int DATA_W    = S_DATA_W
) ();

    logic                   start;
    logic [8*KEY_BYTES-1:0] secret_key;
    logic [DATA_W-1:0]      q;
    logic [ADDR_W-1:0]      address_wr;
    logic [DATA_W-1:0]      data_wr;
    logic                   write;
    logic                   finish;

    modport master (
        input  start, secret_key, q,
        output address_wr, data_wr, write, finish
    );

    modport slave (
        output start, secret_key, q,
        input  address_wr, data_wr, write, finish
    );

endinterface

// File: rtl/ksa_shuffler_key_byte_sel.sv
// Cycles through key bytes modulo KEY_BYTES; byte 0 is the MSB byte of the key.
// Registered index, combinational byte select; advances only when told to.
module key_byte_sel #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   advance,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             key_byte
);

    localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    logic [KIDX_W-1:0] kidx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kidx <= '0;
        end else if (clear) begin
            kidx <= '0;
        end else if (advance) begin
            kidx <= (kidx == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx + KIDX_W'(1);
        end
    end

    always_comb begin
        key_byte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx == KIDX_W'(b)) begin
                key_byte = key[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

endmodule

// File: rtl/ksa_shuffler.sv
// RC4 key schedule over a 256-entry single-port sync RAM: 6 cycles per swap, finish 1537 cycles after start.
// No backpressure; start is only looked at in IDLE and all RAM-side outputs are registered.
module ksa_shuffler
    import ksa_shuffler_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int ADDR_W    = S_ADDR_W,
    parameter int DATA_W    = S_DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    ksa_shuffler_if.master bus
);

    state_t                 state, state_n;
    logic [ADDR_W-1:0]      i, i_n, j, j_n;
    logic [DATA_W-1:0]      si, si_n;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [ADDR_W-1:0]      addr_n;
    logic [DATA_W-1:0]      data_n;
    logic                   write_n, finish_n;
    logic                   key_load, kidx_clear, kidx_advance;
    logic [7:0]             key_byte;

    key_byte_sel #(.KEY_BYTES(KEY_BYTES)) u_key_byte_sel (
        .clk      (clk),
        .rst      (rst),
        .clear    (kidx_clear),
        .advance  (kidx_advance),
        .key      (key_q),
        .key_byte (key_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            i              <= '0;
            j              <= '0;
            si             <= '0;
            key_q          <= '0;
            bus.address_wr <= '0;
            bus.data_wr    <= '0;
            bus.write      <= 1'b0;
            bus.finish     <= 1'b0;
        end else begin
            state          <= state_n;
            i              <= i_n;
            j              <= j_n;
            si             <= si_n;
            bus.address_wr <= addr_n;
            bus.data_wr    <= data_n;
            bus.write      <= write_n;
            bus.finish     <= finish_n;
            if (key_load) begin
                key_q <= bus.secret_key;
            end
        end
    end

    // Outputs are computed for the state being entered, so they are valid throughout that state.
    always_comb begin
        state_n      = state;
        i_n          = i;
        j_n          = j;
        si_n         = si;
        addr_n       = bus.address_wr;
        data_n       = bus.data_wr;
        write_n      = 1'b0;
        finish_n     = 1'b0;
        key_load     = 1'b0;
        kidx_clear   = 1'b0;
        kidx_advance = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    key_load   = 1'b1;
                    kidx_clear = 1'b1;
                    i_n        = '0;
                    j_n        = '0;
                    addr_n     = '0;
                    state_n    = READ_SI;
                end
            end
            READ_SI: state_n = WAIT_SI;
            WAIT_SI: begin
                si_n    = bus.q;
                j_n     = j + ADDR_W'(bus.q) + ADDR_W'(key_byte);
                addr_n  = j_n;
                state_n = READ_SJ;
            end
            READ_SJ: state_n = WAIT_SJ;
            WAIT_SJ: begin
                // S[j] goes straight into the write-data register; it is the sj value for WRITE_SI.
                addr_n  = i;
                data_n  = bus.q;
                write_n = 1'b1;
                state_n = WRITE_SI;
            end
            WRITE_SI: begin
                addr_n  = j;
                data_n  = si;
                write_n = 1'b1;
                state_n = WRITE_SJ;
            end
            WRITE_SJ: begin
                if (&i) begin
                    finish_n = 1'b1;
                    state_n  = DONE;
                end else begin
                    i_n          = i + ADDR_W'(1);
                    kidx_advance = 1'b1;
                    addr_n       = i_n;
                    state_n      = READ_SI;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ksa_shuffler.sv
// Bench for ksa_shuffler: behavioural sync RAM plus a plain-arithmetic RC4 KSA reference.
module tb_ksa_shuffler;
    import ksa_shuffler_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ksa_shuffler_if #(.KEY_BYTES(3)) bus ();

    ksa_shuffler #(.KEY_BYTES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [256];
    logic [7:0] rd_v;
    logic       preload = 1'b0;
    int         ref_s [256];
    int         checks = 0;
    int         failures = 0;

    // Single-port synchronous RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 256; a++) mem[a] = 8'(a);
        end else begin
            rd_v = mem[bus.address_wr];
            if (bus.write === 1'b1) mem[bus.address_wr] = bus.data_wr;
            bus.q <= rd_v;
        end
    end

    task automatic populate();
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        for (int a = 0; a < 256; a++) ref_s[a] = a;
    endtask

    task automatic ksa_model(input logic [23:0] key);
        int jj, t;
        jj = 0;
        for (int ii = 0; ii < 256; ii++) begin
            jj = (jj + ref_s[ii] + int'(key[23 - 8*(ii % 3) -: 8])) % 256;
            t = ref_s[ii]; ref_s[ii] = ref_s[jj]; ref_s[jj] = t;
        end
    endtask

    task automatic start_run(input logic [23:0] key);
        @(negedge clk);
        bus.secret_key = key;
        bus.start = 1'b1;
    endtask

    // Runs from the cycle after start was sampled (k=1) to the IDLE cycle after finish (k=1538).
    task automatic run_body(input logic [23:0] key, input bit disturb, input bit hold,
                            input bit early, input string name);
        int  writes, pat_errs, fin_cnt, fin_at, bad, first_bad;
        bit  exp_w;
        writes = 0; pat_errs = 0; fin_cnt = 0; fin_at = -1; bad = 0; first_bad = -1;
        for (int k = 1; k <= 1538; k++) begin
            @(negedge clk);
            exp_w = (k <= 1536) && (((k - 1) % 6) >= 4);
            if (bus.write !== exp_w) pat_errs++;
            if (bus.write === 1'b1) writes++;
            if (bus.finish === 1'b1) begin fin_cnt++; fin_at = k; end
            if (early && k == 19) begin
                checks++;
                if (mem[0] !== 8'h00 || mem[1] !== 8'h01 || mem[2] !== 8'h03 || mem[3] !== 8'h02) begin
                    failures++;
                    $display("FAIL %s early_swap: S[0..3]=%h %h %h %h, expected 00 01 03 02",
                             name, mem[0], mem[1], mem[2], mem[3]);
                end
            end
            if (disturb && k < 1500) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.secret_key = 24'($urandom);
            end else if (!hold) begin
                bus.start = 1'b0;
            end
        end
        checks++;
        if (writes !== 512) begin
            failures++; $display("FAIL %s write_count: got %0d, expected 512", name, writes);
        end
        checks++;
        if (pat_errs !== 0) begin
            failures++; $display("FAIL %s write_schedule: %0d cycles off the 6-cycle pattern, expected 0", name, pat_errs);
        end
        checks++;
        if (fin_cnt !== 1 || fin_at !== 1537) begin
            failures++; $display("FAIL %s finish_timing: %0d pulse cycles last at +%0d, expected 1 at +1537", name, fin_cnt, fin_at);
        end
        ksa_model(key);
        for (int a = 0; a < 256; a++) begin
            if (mem[a] !== 8'(ref_s[a])) begin
                bad++;
                if (first_bad < 0) first_bad = a;
            end
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL %s final_s: %0d bytes differ, first S[%0d]=%h expected %h",
                     name, bad, first_bad, mem[first_bad], 8'(ref_s[first_bad]));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.secret_key = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.address_wr !== 8'h00 || bus.data_wr !== 8'h00 || bus.write !== 1'b0 || bus.finish !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: addr=%h data=%h write=%b finish=%b, expected 00 00 0 0",
                     bus.address_wr, bus.data_wr, bus.write, bus.finish);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_key();
        populate();
        start_run(24'h000000);
        run_body(24'h000000, 1'b0, 1'b0, 1'b1, "zero_key");
    endtask

    task automatic test_fixed_key();
        populate();
        start_run(24'h000249);
        run_body(24'h000249, 1'b0, 1'b0, 1'b0, "fixed_key");
    endtask

    task automatic test_random_key();
        logic [23:0] key;
        key = 24'($urandom);
        populate();
        start_run(key);
        run_body(key, 1'b0, 1'b0, 1'b0, "random_key");
    endtask

    task automatic test_disturb();
        populate();
        start_run(24'h000249);
        run_body(24'h000249, 1'b1, 1'b0, 1'b0, "disturb");
    endtask

    task automatic test_reset_mid();
        int idle_errs;
        idle_errs = 0;
        populate();
        start_run(24'($urandom));
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
        end
        checks++;
        if (bus.write !== 1'b1) begin
            failures++; $display("FAIL reset_mid_precond: write=%b in WRITE_SI, expected 1", bus.write);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.write !== 1'b0 || bus.address_wr !== 8'h00 || bus.data_wr !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_outputs: write=%b addr=%h data=%h, expected 0 00 00",
                     bus.write, bus.address_wr, bus.data_wr);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.write !== 1'b0 || bus.address_wr !== 8'h00 || bus.finish !== 1'b0) idle_errs++;
        end
        checks++;
        if (idle_errs !== 0) begin
            failures++; $display("FAIL reset_mid_idle: %0d active cycles after release, expected 0", idle_errs);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] key;
        key = 24'($urandom);
        populate();
        start_run(key);
        run_body(key, 1'b0, 1'b1, 1'b0, "b2b_run1");
        run_body(key, 1'b0, 1'b0, 1'b0, "b2b_run2");
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_fixed_key();
        test_random_key();
        test_disturb();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
